display_scan_ctrl: RTL
======================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter ON_CYC, default 1000: clock cycles a digit is driven per slot; legal range >=1.
REQ-002 Parameter BLANK_CYC, default 8: all-digits-off cycles before each slot (anti-ghosting); legal range >=1.
REQ-003 Parameter BLINK_FRAMES, default 64: frames per blink half-period; only used with ERR_BLINK_EN.
REQ-004 Port list SHALL be as follows; the block has one clock, and reset is synchronous and active-high.
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous active-high reset.
- En  in  1  scan enable.
- ERRO  in  1  error flag, drives blinking.
- Dig0..Dig3  in  7 each  segment patterns, active-low, bit0=A..bit6=G.
- SEGs  out  7  segment drive, active-low.
- SEG_D1..SEG_D4  out  1 each  digit enables, active-low.
- SEG_P  out  1  decimal point, active-low; constant 1.
- Sel  out  2  current slot index.
- Frame  out  1  one-cycle pulse at the end of each 4-slot frame.

Function
REQ-005 FSM states SHALL be IDLE, BLANK and SHOW.
- IDLE: all digits off.
- BLANK: BLANK_CYC cycles, SEG_D1..4=1111, SEGs=7'h7F.
- SHOW: ON_CYC cycles, exactly one SEG_Dn=0.
REQ-006 Slot mapping SHALL be Sel=0 to SEG_D1/Dig0, 1 to SEG_D2/Dig1, 2 to SEG_D3/Dig2, 3 to SEG_D4/Dig3.
REQ-007 In IDLE with En=1, the next state SHALL be BLANK with Sel=0.
REQ-008 BLANK SHALL go to SHOW after BLANK_CYC cycles.
REQ-009 SHOW SHALL go to BLANK with Sel+1 after ON_CYC cycles; Sel wraps 3 to 0.
REQ-010 Frame SHALL pulse for exactly one cycle, coincident with the 3-to-0 wrap.
- Frame period = 4*(BLANK_CYC+ON_CYC) cycles.
REQ-011 Dig0..Dig3 SHALL be captured into shadow registers on every entry to BLANK with Sel=0.
- Displayed patterns never change mid-frame (no tearing).
REQ-012 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-013 En sampled 0 in any state SHALL force IDLE on the next edge.
- Sel=0, all digits off, Frame=0, timer cleared.
- No partial slot is completed.
REQ-014 En re-asserted SHALL restart scanning from BLANK slot 0 with a fresh capture.
REQ-015 The slot timer SHALL be a down-counter of width $clog2(max(ON_CYC,BLANK_CYC)+1) that never wraps past 0.

Reset
REQ-016 While Rst=1, the block SHALL hold the following on the next edge; Rst overrides En.
- state IDLE, Sel=0, Frame=0.
- SEGs=7'h7F, SEG_D1..4=1111, SEG_P=1.
- shadow registers=7'h7F, blink counter=0, blink phase=on.

Configuration
REQ-017 With ERR_BLINK_EN defined, a frame counter SHALL toggle blink phase every BLINK_FRAMES Frame pulses.
- While ERRO=1 and phase=off, SHOW drives SEG_D1..4=1111.
- Timing and Sel are unaffected.
- ERRO=0 clears the counter and sets phase=on at the next edge.
REQ-018 Without ERR_BLINK_EN, ERRO SHALL be ignored and no blink logic SHALL be instantiated.

Structure
REQ-019 Shared package disp_pkg SHALL hold the following; Dig patterns are supplied by the existing decoders.
- state enum.
- SEG_OFF=7'h7F.
- DIG_OFF=4'b1111.
- NUM_SLOTS=4.
REQ-020 One sub-module, scan_timer, SHALL be used: a loadable down-counter with a done flag, instantiated once.

Verification (ON_CYC=4, BLANK_CYC=2, BLINK_FRAMES=2)
REQ-021 Rst=1 for 3 cycles, then En=1 SHALL give the following.
- 2 cycles with SEG_D=1111.
- then 4 cycles with SEG_D1=0, SEGs=Dig0.
- Frame first high 24 cycles after entering BLANK slot 0.
REQ-022 Dig0 changed from 7'h40 to 7'h79 during slot 2 SHALL give the following.
- Slot 0 of the current frame still shows 7'h40.
- The next frame shows 7'h79.
REQ-023 En dropped during SHOW of slot 2 SHALL give all outputs off and Sel=0 next cycle.
- Re-enable restarts at BLANK slot 0.
REQ-024 Rst asserted mid-SHOW with En=1 SHALL give reset values next edge.
- Scanning resumes only after Rst=0.
REQ-025 With ERR_BLINK_EN and ERRO=1, digits SHALL be shown for 2 frames and dark for 2 frames, repeating.
- Without the macro, digits are never dark in SHOW.
REQ-026 Sel SHALL visit 0,1,2,3,0 over 5 slots, with exactly one SEG_Dn low in every SHOW cycle.

Source files
------------

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared types and constants for the 4-digit display scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [3:0] DIG_OFF   = 4'b1111;
    localparam int         NUM_SLOTS = 4;

    // Active-low digit enable for a slot: exactly one bit low.
    function automatic logic [3:0] slot_enable(input logic [1:0] sel);
        slot_enable = ~(4'b0001 << sel);
    endfunction

endpackage : disp_pkg
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : scan_timer
// Description : Loadable down-counter that saturates at zero; done when zero.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule : scan_timer
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : 4-digit multiplexed 7-segment scanner with blanking gaps and
//               frame-coherent digit capture. Define ERR_BLINK_EN to enable
//               error blinking driven by ERRO.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int ON_CYC       = 1000,
    parameter int BLANK_CYC    = 8,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       En,
    input  logic       ERRO,
    input  logic [6:0] Dig0,
    input  logic [6:0] Dig1,
    input  logic [6:0] Dig2,
    input  logic [6:0] Dig3,
    output logic [6:0] SEGs,
    output logic       SEG_D1,
    output logic       SEG_D2,
    output logic       SEG_D3,
    output logic       SEG_D4,
    output logic       SEG_P,
    output logic [1:0] Sel,
    output logic       Frame
);

    localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] ON_LOAD    = TW'(ON_CYC - 1);
    localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYC - 1);

    scan_state_e state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic        frame_q, frame_d;
    logic [6:0]  segs_q, segs_d;
    logic [3:0]  dig_en_q, dig_en_d;
    logic [6:0]  shadow_q [NUM_SLOTS];

    logic          w_capture;
    logic          w_tmr_clr;
    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic          w_tmr_done;
    logic          w_dark;

    scan_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk        (Clk),
        .rst        (Rst),
        .clr_i      (w_tmr_clr),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .done_o     (w_tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        frame_d    = 1'b0;
        w_capture  = 1'b0;
        w_tmr_clr  = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        if (!En) begin
            // Abandon any partial slot; restart cleanly on re-enable.
            state_d   = ST_IDLE;
            sel_d     = 2'd0;
            w_tmr_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_BLANK;
                    sel_d      = 2'd0;
                    w_capture  = 1'b1;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = BLANK_LOAD;
                end
                ST_BLANK: begin
                    if (w_tmr_done) begin
                        state_d    = ST_SHOW;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = ON_LOAD;
                    end
                end
                ST_SHOW: begin
                    if (w_tmr_done) begin
                        state_d    = ST_BLANK;
                        sel_d      = sel_q + 2'd1;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = BLANK_LOAD;
                        if (sel_q == 2'd3) begin
                            frame_d   = 1'b1;
                            w_capture = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sel_d   = 2'd0;
                end
            endcase
        end
    end

`ifdef ERR_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_on_q, phase_on_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_on_d  = phase_on_q;
        if (!ERRO) begin
            blink_cnt_d = '0;
            phase_on_d  = 1'b1;
        end else if (frame_d) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_on_d  = ~phase_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_on_q  <= phase_on_d;
        end
    end

    assign w_dark = ERRO & ~phase_on_d;
`else
    logic unused_blink;
    assign unused_blink = ERRO ^ BLINK_FRAMES[0];
    assign w_dark       = 1'b0;
`endif

    // Outputs are registered from next-state so they align with state_q.
    always_comb begin
        segs_d   = SEG_OFF;
        dig_en_d = DIG_OFF;
        if (state_d == ST_SHOW) begin
            segs_d   = shadow_q[sel_d];
            dig_en_d = w_dark ? DIG_OFF : slot_enable(sel_d);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 2'd0;
            frame_q     <= 1'b0;
            segs_q      <= SEG_OFF;
            dig_en_q    <= DIG_OFF;
            shadow_q[0] <= SEG_OFF;
            shadow_q[1] <= SEG_OFF;
            shadow_q[2] <= SEG_OFF;
            shadow_q[3] <= SEG_OFF;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            frame_q  <= frame_d;
            segs_q   <= segs_d;
            dig_en_q <= dig_en_d;
            if (w_capture) begin
                shadow_q[0] <= Dig0;
                shadow_q[1] <= Dig1;
                shadow_q[2] <= Dig2;
                shadow_q[3] <= Dig3;
            end
        end
    end

    assign SEGs   = segs_q;
    assign SEG_D1 = dig_en_q[0];
    assign SEG_D2 = dig_en_q[1];
    assign SEG_D3 = dig_en_q[2];
    assign SEG_D4 = dig_en_q[3];
    assign SEG_P  = 1'b1;
    assign Sel    = sel_q;
    assign Frame  = frame_q;

endmodule : display_scan_ctrl
`default_nettype wire
